// File: rtl/hvac_sensor_cond.sv
// hvac_sensor_cond: conditioning stage in front of the HVAC control FSM.
// Temperature path: setpoint compares with hysteresis, sample persistence
// and a NORM/HOT/COLD state machine producing the t_cao/t_thap flags.
// Button path: 2-flop synchronizer, debounce counter and a toggle that
// turns each accepted press into a change of the keypad (fan request) level.
// Every output comes straight from a flop.
module hvac_sensor_cond #(
   parameter int unsigned TW      = 8,
   parameter int unsigned HYST    = 2,
   parameter int unsigned PERSIST = 3,
   parameter int unsigned DB_CYC  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [TW-1:0] temp,
   input  logic          temp_vld,
   input  logic [TW-1:0] sp_hi,
   input  logic [TW-1:0] sp_lo,
   input  logic          btn,
   output logic          t_cao,
   output logic          t_thap,
   output logic          keypad,
   output logic          cfg_err
);

   // Counter widths hold the full terminal count.
   localparam int unsigned PW = $clog2(PERSIST + 1);
   localparam int unsigned DW = $clog2(DB_CYC + 1);
   // Two spare bits so that sp_lo + 2*HYST can never wrap.
   localparam int unsigned XW = TW + 2;
   localparam logic [XW-1:0] HYST_X = XW'(HYST);
   localparam logic [XW-1:0] TMAX_X = {2'b00, {TW{1'b1}}};

   typedef enum logic [1:0] {
      NORM = 2'd0,
      HOT  = 2'd1,
      COLD = 2'd2
   } tstate_t;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

   // ---------------------------------------------------------------------
   // Threshold arithmetic
   // ---------------------------------------------------------------------
   logic [XW-1:0] temp_x;
   logic [XW-1:0] hi_x;
   logic [XW-1:0] lo_x;
   logic [XW-1:0] hi_rel;
   logic [XW-1:0] lo_rel;
   logic          cfg_bad;
   logic          is_up;
   logic          is_dn;
   logic          rel_hot;
   logic          rel_cold;

   assign temp_x = XW'(temp);
   assign hi_x   = XW'(sp_hi);
   assign lo_x   = XW'(sp_lo);

   // Release thresholds: saturate instead of wrapping at either end of the range.
   always_comb begin : rel_thresholds
      // NOTE: every signal driven here gets a value on every path; a missing default in always_comb infers a latch.
      hi_rel = '0;
      lo_rel = TMAX_X;
      if (hi_x >= HYST_X) begin
         hi_rel = hi_x - HYST_X;
      end
      if ((lo_x + HYST_X) <= TMAX_X) begin
         lo_rel = lo_x + HYST_X;
      end
   end

   // The two hysteresis bands must not overlap, otherwise the setpoints are unusable.
   assign cfg_bad  = (lo_x + HYST_X + HYST_X) > hi_x;
   assign is_up    = temp_x > hi_x;
   assign is_dn    = temp_x < lo_x;
   assign rel_hot  = temp_x <= hi_rel;
   assign rel_cold = temp_x >= lo_rel;

   // ---------------------------------------------------------------------
   // Temperature state machine with persistence
   // ---------------------------------------------------------------------
   tstate_t       state;
   tstate_t       state_nxt;
   dir_t          dir;
   dir_t          dir_nxt;
   dir_t          dir_smp;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_nxt;
   logic [PW-1:0] run;
   logic          qual;

   // Qualification of the current sample against the pending condition, and the run length it would give.
   always_comb begin : sample_qual
      dir_smp = is_up ? DIR_UP : DIR_DN;
      qual    = 1'b0;
      case (state)
         NORM:    qual = is_up | is_dn;
         HOT:     qual = rel_hot;
         COLD:    qual = rel_cold;
         default: qual = 1'b0;
      endcase
      // In NORM a sample in the other direction than the one being counted starts a new run.
      if ((state == NORM) && (dir_smp != dir)) begin
         run = PW'(1);
      end else begin
         run = pcnt + PW'(1);
      end
   end

   // Next state, persistence count and candidate direction.
   always_comb begin : fsm_next
      state_nxt = state;
      pcnt_nxt  = pcnt;
      dir_nxt   = dir;
      if (cfg_bad) begin
         state_nxt = NORM;
         pcnt_nxt  = '0;
      end else if (temp_vld) begin
         if (!qual) begin
            pcnt_nxt = '0;
         end else if (run == PW'(PERSIST)) begin
            pcnt_nxt = '0;
            case (state)
               NORM:    state_nxt = (dir_smp == DIR_UP) ? HOT : COLD;
               default: state_nxt = NORM;
            endcase
         end else begin
            pcnt_nxt = run;
            if (state == NORM) begin
               dir_nxt = dir_smp;
            end
         end
      end
   end

   // State register; the flags are registered from the next state so they change together with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= NORM;
         pcnt    <= '0;
         dir     <= DIR_UP;
         t_cao   <= 1'b0;
         t_thap  <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
         state   <= state_nxt;
         pcnt    <= pcnt_nxt;
         dir     <= dir_nxt;
         t_cao   <= (state_nxt == HOT);
         t_thap  <= (state_nxt == COLD);
         cfg_err <= cfg_bad;
      end
   end

   // ---------------------------------------------------------------------
   // Button synchronizer, debounce and toggle
   // ---------------------------------------------------------------------
   logic          s1;
   logic          s2;
   logic          btn_db;
   logic [DW-1:0] db_cnt;
   logic [DW-1:0] db_inc;
   logic          db_hit;

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   // Acceptance happens on the edge where the mismatch count reaches DB_CYC.
   always_comb begin : db_accept
      db_inc = db_cnt + DW'(1);
      db_hit = (s2 != btn_db) && (db_inc == DW'(DB_CYC));
   end

   // Debounce counter, debounced level and press toggle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt <= '0;
         btn_db <= 1'b0;
         keypad <= 1'b0;
      end else begin
         if (s2 == btn_db) begin
            db_cnt <= '0;
         end else if (db_hit) begin
            db_cnt <= '0;
            btn_db <= s2;
         end else begin
            db_cnt <= db_inc;
         end
         // Only a debounced 0->1 (a press) flips the fan request.
         if (db_hit && s2) begin
            keypad <= ~keypad;
         end
      end
   end

endmodule
